rtype_exec_ctrl: RTL and testbench
==================================

Name: rtype_exec_ctrl

Overview:
Multi-cycle controller that sequences the shared R-type ALU (one-hot enables Radd_en..Rsra_en, operands read_data1/read_data2, result alu_out).
- Accepts one 32-bit RV32I instruction per transaction on a valid/ready handshake.
- Decodes the instruction, drives register-file read addresses and exactly one ALU enable, captures alu_out, and issues the register-file write-back.
- Sits between instruction fetch and the regfile/ALU pair. The regfile read ports feed the ALU directly.

Parameters:
CNT_W, 16, width of the retired and illegal instruction counters (wrap-around)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
instr_valid  input  1  instruction offered
instr  input  32  instruction word
instr_ready  output  1  controller can accept (IDLE only)
rs1_addr  output  5  regfile read address 1 (instr[19:15])
rs2_addr  output  5  regfile read address 2 (instr[24:20])
Radd_en,Rsub_en,Ror_en,Rxor_en,Rand_en,Rslt_en,Rsltu_en,Rsll_en,Rsrl_en,Rsra_en  output  1 each  ALU one-hot operation enables
alu_out  input  32  ALU result (combinational from enables and operands)
wr_en  output  1  regfile write strobe
wr_addr  output  5  regfile write address (rd)
wr_data  output  32  regfile write data
done  output  1  one-cycle pulse on retire
illegal  output  1  one-cycle pulse on rejected instruction
retired_cnt  output  CNT_W  count of retired instructions
illegal_cnt  output  CNT_W  count of rejected instructions

Behaviour:
- Reset is asynchronous and active-high and may occur in any state, including mid-operation. On reset:
  - state=IDLE, instr_ready=1.
  - All enables=0, wr_en=0, done=0, illegal=0.
  - wr_addr=0, wr_data=0, rs1_addr=0, rs2_addr=0, both counters=0, instruction register=0.
  - Any in-flight instruction is dropped with no write.
- States: IDLE -> DECODE -> EXEC -> WB -> IDLE. Illegal path: DECODE -> IDLE.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, latch instr and go to DECODE.
- DECODE:
  - rs1_addr/rs2_addr driven from the latched instr. They hold those values through EXEC and WB.
  - Legal requires opcode[6:0]=0110011 and (funct7,funct3) in this set:
    - ADD 0000000/000, SUB 0100000/000
    - SLL 0000000/001, SLT 0000000/010, SLTU 0000000/011
    - XOR 0000000/100, SRL 0000000/101, SRA 0100000/101
    - OR 0000000/110, AND 0000000/111
  - Legal -> EXEC.
  - Illegal -> IDLE, with illegal=1 for exactly one cycle (registered, asserted in the following IDLE cycle) and illegal_cnt+1.
- EXEC:
  - Exactly one enable is high, for exactly one cycle, all others 0.
  - alu_out is sampled into wr_data at the end of EXEC.
- WB:
  - wr_addr=rd (instr[11:7]) and done=1.
  - wr_en=1 unless rd==0; rd==0 suppresses the write but still retires and counts.
  - retired_cnt+1.
  - Next state IDLE.
- Outside EXEC all enables=0. Outside WB wr_en=0 and done=0.
- Latency:
  - Handshake at edge N.
  - Enables high in cycle N+2.
  - wr_en/done high in cycle N+3.
  - instr_ready high again in cycle N+4.
  - Maximum throughput is 1 instruction per 4 cycles.
- instr_valid while not IDLE is ignored (no ready). The offered instr may change freely.
- Counters wrap from 2^CNT_W-1 to 0.
- wr_data holds its last value until the next EXEC.

Test Plan:
- Reset then ADD x3,x1,x2 (0x002081B3), regfile x1=9, x2=3 -> rs1_addr=1, rs2_addr=2, Radd_en pulse only, then wr_en=1, wr_addr=3, wr_data=12, done pulse, retired_cnt=1, all exactly 2/3 cycles after handshake.
- SUB 0x402081B3 and SRA x5,x1,x2 0x4020D2B3 with x1=0xFFFFFFF0, x2=2 -> Rsub_en then wr_data=0xFFFFFFEE; Rsra_en then wr_addr=5, wr_data=0xFFFFFFFC.
- Illegal MUL 0x022081B3 and I-type opcode 0x00208013 -> no enable, no wr_en, illegal pulse each, illegal_cnt=2, retired_cnt unchanged, instr_ready back high.
- ADD x0,x1,x2 (0x00208033) -> Radd_en pulse, done pulse, wr_en stays 0, retired_cnt increments.
- Hold instr_valid high with 10 back-to-back different instructions covering all ten ops -> instr_ready low 3 cycles after each accept, each enable seen exactly once in order, no instruction lost or duplicated.
- Assert rst during EXEC of AND -> all outputs immediately 0, counters 0, no wr_en ever seen for that instruction, next instruction processed normally. Separately, set CNT_W=2 and run 5 retires -> retired_cnt=1.

Source files
------------

// File: rtl/rtype_exec_ctrl_if.sv
// Bundle of instruction handshake, regfile and ALU-control signals
// around the R-type execution controller.
interface rtype_exec_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             instr_valid;
  logic [31:0]      instr;
  logic             instr_ready;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic             Radd_en;
  logic             Rsub_en;
  logic             Ror_en;
  logic             Rxor_en;
  logic             Rand_en;
  logic             Rslt_en;
  logic             Rsltu_en;
  logic             Rsll_en;
  logic             Rsrl_en;
  logic             Rsra_en;
  logic [31:0]      alu_out;
  logic             wr_en;
  logic [4:0]       wr_addr;
  logic [31:0]      wr_data;
  logic             done;
  logic             illegal;
  logic [CNT_W-1:0] retired_cnt;
  logic [CNT_W-1:0] illegal_cnt;

  // Controller side: consumes instructions and ALU result, drives everything else
  modport master (
    input  instr_valid, instr, alu_out,
    output instr_ready, rs1_addr, rs2_addr,
           Radd_en, Rsub_en, Ror_en, Rxor_en, Rand_en,
           Rslt_en, Rsltu_en, Rsll_en, Rsrl_en, Rsra_en,
           wr_en, wr_addr, wr_data, done, illegal,
           retired_cnt, illegal_cnt
  );

  // Environment side: fetch, regfile and ALU
  modport slave (
    output instr_valid, instr, alu_out,
    input  instr_ready, rs1_addr, rs2_addr,
           Radd_en, Rsub_en, Ror_en, Rxor_en, Rand_en,
           Rslt_en, Rsltu_en, Rsll_en, Rsrl_en, Rsra_en,
           wr_en, wr_addr, wr_data, done, illegal,
           retired_cnt, illegal_cnt
  );
endinterface

// File: rtl/rtype_exec_ctrl.sv
// Four-state sequencer for RV32I R-type instructions: accepts one instruction,
// decodes it, pulses exactly one ALU enable, captures the result and issues
// the regfile write-back. Illegal words are rejected straight back to IDLE.
module rtype_exec_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  rtype_exec_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  // Bit positions of the one-hot operation vector, in enable-port order
  localparam int IDX_ADD  = 0;
  localparam int IDX_SUB  = 1;
  localparam int IDX_OR   = 2;
  localparam int IDX_XOR  = 3;
  localparam int IDX_AND  = 4;
  localparam int IDX_SLT  = 5;
  localparam int IDX_SLTU = 6;
  localparam int IDX_SLL  = 7;
  localparam int IDX_SRL  = 8;
  localparam int IDX_SRA  = 9;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t           state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic [9:0] op_oh;
  logic [9:0] exec_oh;
  logic       legal;

  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign funct3 = instr_q[14:12];
  assign funct7 = instr_q[31:25];

  // Decode the latched instruction into a one-hot operation; all-zero means illegal
  always_comb begin
    op_oh = '0;
    if (opcode == 7'b0110011) begin
      case ({funct7, funct3})
        10'b0000000_000: op_oh[IDX_ADD]  = 1'b1;
        10'b0100000_000: op_oh[IDX_SUB]  = 1'b1;
        10'b0000000_001: op_oh[IDX_SLL]  = 1'b1;
        10'b0000000_010: op_oh[IDX_SLT]  = 1'b1;
        10'b0000000_011: op_oh[IDX_SLTU] = 1'b1;
        10'b0000000_100: op_oh[IDX_XOR]  = 1'b1;
        10'b0000000_101: op_oh[IDX_SRL]  = 1'b1;
        10'b0100000_101: op_oh[IDX_SRA]  = 1'b1;
        10'b0000000_110: op_oh[IDX_OR]   = 1'b1;
        10'b0000000_111: op_oh[IDX_AND]  = 1'b1;
        default:         op_oh           = '0;
      endcase
    end
  end

  assign legal = |op_oh;

  // Next-state logic: sequencing, instruction latch, result capture and counters
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    wr_data_d     = wr_data_q;
    illegal_d     = 1'b0;
    retired_d     = retired_q;
    illegal_cnt_d = illegal_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.instr_valid) begin
          instr_d = bus.instr;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (legal) begin
          state_d = EXEC;
        end else begin
          state_d       = IDLE;
          illegal_d     = 1'b1;
          illegal_cnt_d = illegal_cnt_q + CNT_ONE;
        end
      end
      EXEC: begin
        wr_data_d = bus.alu_out;
        state_d   = WB;
      end
      WB: begin
        retired_d = retired_q + CNT_ONE;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      instr_q       <= '0;
      wr_data_q     <= '0;
      illegal_q     <= 1'b0;
      retired_q     <= '0;
      illegal_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      wr_data_q     <= wr_data_d;
      illegal_q     <= illegal_d;
      retired_q     <= retired_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  // Enables are only ever live during the single EXEC cycle
  always_comb begin
    exec_oh = '0;
    if (state_q == EXEC) begin
      exec_oh = op_oh;
    end
  end

  assign bus.instr_ready = (state_q == IDLE);
  assign bus.rs1_addr    = instr_q[19:15];
  assign bus.rs2_addr    = instr_q[24:20];

  assign bus.Radd_en  = exec_oh[IDX_ADD];
  assign bus.Rsub_en  = exec_oh[IDX_SUB];
  assign bus.Ror_en   = exec_oh[IDX_OR];
  assign bus.Rxor_en  = exec_oh[IDX_XOR];
  assign bus.Rand_en  = exec_oh[IDX_AND];
  assign bus.Rslt_en  = exec_oh[IDX_SLT];
  assign bus.Rsltu_en = exec_oh[IDX_SLTU];
  assign bus.Rsll_en  = exec_oh[IDX_SLL];
  assign bus.Rsrl_en  = exec_oh[IDX_SRL];
  assign bus.Rsra_en  = exec_oh[IDX_SRA];

  // Writes to x0 still retire, they just never strobe the regfile
  assign bus.done        = (state_q == WB);
  assign bus.wr_en       = (state_q == WB) && (rd != 5'd0);
  assign bus.wr_addr     = rd;
  assign bus.wr_data     = wr_data_q;
  assign bus.illegal     = illegal_q;
  assign bus.retired_cnt = retired_q;
  assign bus.illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_rtype_exec_ctrl.sv
// Self-checking bench for rtype_exec_ctrl: directed vector table with
// cycle-exact checks, back-to-back and randomized streams scored against an
// instruction-level reference model, mid-EXEC reset, and counter wrap.
`timescale 1ns/1ps
module tb_rtype_exec_ctrl;
  localparam int CNT_W = 16;

  localparam int OP_ADD = 0, OP_SUB = 1, OP_OR = 2, OP_XOR = 3, OP_AND = 4;
  localparam int OP_SLT = 5, OP_SLTU = 6, OP_SLL = 7, OP_SRL = 8, OP_SRA = 9;

  // {funct7, funct3} of each operation, indexed in enable-port order
  localparam logic [9:0] OP_KEYS [10] = '{
    10'b0000000_000, 10'b0100000_000, 10'b0000000_110, 10'b0000000_100,
    10'b0000000_111, 10'b0000000_010, 10'b0000000_011, 10'b0000000_001,
    10'b0000000_101, 10'b0100000_101};

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] v1;
    logic [31:0] v2;
    bit          isIllegal;
    int          op;
    bit          we;
    logic [4:0]  addr;
    logic [31:0] data;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rtype_exec_ctrl_if #(.CNT_W(CNT_W)) bus ();
  rtype_exec_ctrl_if #(.CNT_W(2))     bus2 ();

  rtype_exec_ctrl #(.CNT_W(CNT_W)) dut  (.clk(clk), .rst(rst), .bus(bus.master));
  rtype_exec_ctrl #(.CNT_W(2))     dut2 (.clk(clk), .rst(rst), .bus(bus2.master));

  logic [31:0]      rf [32];
  logic [9:0]       enVec;
  logic [49:0]      evQ [$];
  logic [49:0]      expQ [$];
  logic [31:0]      txQ [$];
  vec_t             vecs [$];
  bit               monOn = 1'b0;
  int               nCompared = 0;
  int               nMismatched = 0;
  logic [CNT_W-1:0] expRet;
  logic [CNT_W-1:0] expIll;

  assign enVec = {bus.Rsra_en, bus.Rsrl_en, bus.Rsll_en, bus.Rsltu_en, bus.Rslt_en,
                  bus.Rand_en, bus.Rxor_en, bus.Ror_en, bus.Rsub_en, bus.Radd_en};

  function automatic logic [31:0] refAlu(input int op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_AND:  return a & b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return $signed(a) >>> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  // Returns the operation index, or -1 for any word the controller must reject
  function automatic int refDecode(input logic [31:0] w);
    if (w[6:0] != 7'b0110011) return -1;
    for (int k = 0; k < 10; k++) begin
      if ({w[31:25], w[14:12]} == OP_KEYS[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [31:0] mkR(input int op, input int rd, input int rs1, input int rs2);
    logic [9:0] key;
    key = OP_KEYS[op];
    return {key[9:3], 5'(rs2), 5'(rs1), key[2:0], 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [49:0] mkEv(input logic [1:0] kind, input logic [9:0] en,
                                       input logic we, input logic [4:0] a, input logic [31:0] d);
    return {kind, en, we, a, d};
  endfunction

  // Regfile read ports feeding an ideal ALU selected by the enables
  always_comb begin
    bus.alu_out = 32'h0;
    for (int k = 0; k < 10; k++) begin
      if (enVec[k]) bus.alu_out = refAlu(k, rf[bus.rs1_addr], rf[bus.rs2_addr]);
    end
  end

  assign bus2.alu_out = 32'h0;

  // Event monitor: records every enable, retire and illegal pulse in order
  always @(negedge clk) begin
    if (monOn) begin
      if (enVec != 10'd0) evQ.push_back(mkEv(2'd1, enVec, 1'b0, 5'd0, 32'd0));
      if (bus.done || bus.wr_en) evQ.push_back(mkEv(2'd2, 10'd0, bus.wr_en, bus.wr_addr, bus.wr_data));
      if (bus.illegal) evQ.push_back(mkEv(2'd3, 10'd0, 1'b0, 5'd0, 32'd0));
    end
  end

  // Global time bound so the bench can never hang
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkEvents(input string tag);
    checkOutput({tag, " event count"}, 64'(evQ.size()), 64'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < evQ.size(); i++) begin
      checkOutput({tag, " event"}, 64'(evQ[i]), 64'(expQ[i]));
    end
    evQ.delete();
    expQ.delete();
  endtask

  // Reference model: what one accepted instruction must eventually produce
  task automatic expectInstr(input logic [31:0] w);
    int op;
    logic [9:0] oh;
    op = refDecode(w);
    if (op < 0) begin
      expQ.push_back(mkEv(2'd3, 10'd0, 1'b0, 5'd0, 32'd0));
      expIll = expIll + 1'b1;
    end else begin
      oh = '0;
      oh[op] = 1'b1;
      expQ.push_back(mkEv(2'd1, oh, 1'b0, 5'd0, 32'd0));
      expQ.push_back(mkEv(2'd2, 10'd0, w[11:7] != 5'd0, w[11:7],
                          refAlu(op, rf[w[19:15]], rf[w[24:20]])));
      expRet = expRet + 1'b1;
    end
  endtask

  task automatic addVec(input string n, input logic [31:0] w, input logic [31:0] v1, input logic [31:0] v2,
                        input bit ill, input int op, input bit we, input logic [4:0] a, input logic [31:0] d);
    vec_t v;
    v.name = n; v.instr = w; v.v1 = v1; v.v2 = v2; v.isIllegal = ill;
    v.op = op; v.we = we; v.addr = a; v.data = d;
    vecs.push_back(v);
  endtask

  // One instruction with cycle-exact checks; entered and left at an IDLE negedge
  task automatic applyStimulus(input vec_t v);
    logic [9:0] expOh;
    if (v.instr[19:15] != 5'd0) rf[v.instr[19:15]] = v.v1;
    if (v.instr[24:20] != 5'd0) rf[v.instr[24:20]] = v.v2;
    expOh = '0;
    if (!v.isIllegal) expOh[v.op] = 1'b1;
    checkOutput({v.name, " ready before"}, 64'(bus.instr_ready), 64'd1);
    bus.instr_valid = 1'b1;
    bus.instr = v.instr;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    bus.instr = $urandom;
    @(negedge clk);
    checkOutput({v.name, " decode ready"}, 64'(bus.instr_ready), 64'd0);
    checkOutput({v.name, " decode enables"}, 64'(enVec), 64'd0);
    checkOutput({v.name, " decode done"}, 64'(bus.done), 64'd0);
    checkOutput({v.name, " rs1_addr"}, 64'(bus.rs1_addr), 64'(v.instr[19:15]));
    checkOutput({v.name, " rs2_addr"}, 64'(bus.rs2_addr), 64'(v.instr[24:20]));
    @(negedge clk);
    if (v.isIllegal) begin
      expIll = expIll + 1'b1;
      checkOutput({v.name, " illegal pulse"}, 64'(bus.illegal), 64'd1);
      checkOutput({v.name, " ready after reject"}, 64'(bus.instr_ready), 64'd1);
      checkOutput({v.name, " no enable"}, 64'(enVec), 64'd0);
      checkOutput({v.name, " illegal_cnt"}, 64'(bus.illegal_cnt), 64'(expIll));
      checkOutput({v.name, " retired_cnt"}, 64'(bus.retired_cnt), 64'(expRet));
      @(negedge clk);
      checkOutput({v.name, " illegal one cycle"}, 64'(bus.illegal), 64'd0);
      checkOutput({v.name, " no wr_en"}, 64'(bus.wr_en), 64'd0);
    end else begin
      checkOutput({v.name, " exec enables"}, 64'(enVec), 64'(expOh));
      checkOutput({v.name, " exec wr_en"}, 64'(bus.wr_en), 64'd0);
      checkOutput({v.name, " exec done"}, 64'(bus.done), 64'd0);
      @(negedge clk);
      checkOutput({v.name, " wb enables"}, 64'(enVec), 64'd0);
      checkOutput({v.name, " wb done"}, 64'(bus.done), 64'd1);
      checkOutput({v.name, " wb wr_en"}, 64'(bus.wr_en), 64'(v.we));
      checkOutput({v.name, " wb wr_addr"}, 64'(bus.wr_addr), 64'(v.addr));
      checkOutput({v.name, " wb wr_data"}, 64'(bus.wr_data), 64'(v.data));
      checkOutput({v.name, " wb rs1 hold"}, 64'(bus.rs1_addr), 64'(v.instr[19:15]));
      expRet = expRet + 1'b1;
      @(negedge clk);
      checkOutput({v.name, " ready again"}, 64'(bus.instr_ready), 64'd1);
      checkOutput({v.name, " done one cycle"}, 64'(bus.done), 64'd0);
      checkOutput({v.name, " wr_en one cycle"}, 64'(bus.wr_en), 64'd0);
      checkOutput({v.name, " retired_cnt"}, 64'(bus.retired_cnt), 64'(expRet));
      checkOutput({v.name, " wr_data hold"}, 64'(bus.wr_data), 64'(v.data));
    end
  endtask

  // Feeds txQ to the DUT; holdValid keeps valid high with the next word offered
  task automatic runStream(input bit holdValid, input int maxCycles);
    int lastAcc;
    bit acc;
    lastAcc = -1;
    for (int cyc = 0; cyc < maxCycles && txQ.size() > 0; cyc++) begin
      if (holdValid) begin
        bus.instr_valid = 1'b1;
        bus.instr = txQ[0];
      end else if (bus.instr_ready) begin
        bus.instr_valid = ($urandom_range(0, 3) != 0);
        bus.instr = bus.instr_valid ? txQ[0] : $urandom;
      end else begin
        bus.instr_valid = ($urandom_range(0, 1) == 1);
        bus.instr = $urandom;
      end
      acc = bus.instr_valid && bus.instr_ready;
      @(posedge clk);
      if (acc) begin
        expectInstr(txQ.pop_front());
        if (holdValid && lastAcc >= 0) checkOutput("b2b accept spacing", 64'(cyc - lastAcc), 64'd4);
        lastAcc = cyc;
      end
      @(negedge clk);
    end
    bus.instr_valid = 1'b0;
    checkOutput("stream drained", 64'(txQ.size()), 64'd0);
  endtask

  initial begin
    int nAcc;
    int sel;
    bit acc2;
    logic [31:0] w;

    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr = 32'h0;
    bus2.instr_valid = 1'b0;
    bus2.instr = 32'h0;
    for (int k = 0; k < 32; k++) rf[k] = 32'h0;
    expRet = '0;
    expIll = '0;

    addVec("add",    32'h002081B3, 32'd9,        32'd3, 0, OP_ADD,  1, 5'd3, 32'd12);
    addVec("sub",    32'h402081B3, 32'hFFFFFFF0, 32'd2, 0, OP_SUB,  1, 5'd3, 32'hFFFFFFEE);
    addVec("sra",    32'h4020D2B3, 32'hFFFFFFF0, 32'd2, 0, OP_SRA,  1, 5'd5, 32'hFFFFFFFC);
    addVec("mul",    32'h022081B3, 32'd9,        32'd3, 1, 0,       0, 5'd0, 32'd0);
    addVec("itype",  32'h00208013, 32'd9,        32'd3, 1, 0,       0, 5'd0, 32'd0);
    addVec("add x0", 32'h00208033, 32'd9,        32'd3, 0, OP_ADD,  0, 5'd0, 32'd12);
    addVec("slt",    32'h0020A1B3, 32'hFFFFFFFF, 32'd1, 0, OP_SLT,  1, 5'd3, 32'd1);
    addVec("sltu",   32'h0020B1B3, 32'hFFFFFFFF, 32'd1, 0, OP_SLTU, 1, 5'd3, 32'd0);
    addVec("srl",    32'h0020D1B3, 32'hFFFFFFF0, 32'd4, 0, OP_SRL,  1, 5'd3, 32'h0FFFFFFF);
    addVec("sll",    32'h002091B3, 32'h0000000F, 32'd36, 0, OP_SLL, 1, 5'd3, 32'h000000F0);

    repeat (2) @(negedge clk);
    checkOutput("reset ready", 64'(bus.instr_ready), 64'd1);
    checkOutput("reset enables", 64'(enVec), 64'd0);
    checkOutput("reset wr_en", 64'(bus.wr_en), 64'd0);
    checkOutput("reset done", 64'(bus.done), 64'd0);
    checkOutput("reset illegal", 64'(bus.illegal), 64'd0);
    checkOutput("reset wr_addr", 64'(bus.wr_addr), 64'd0);
    checkOutput("reset wr_data", 64'(bus.wr_data), 64'd0);
    checkOutput("reset rs1_addr", 64'(bus.rs1_addr), 64'd0);
    checkOutput("reset rs2_addr", 64'(bus.rs2_addr), 64'd0);
    checkOutput("reset retired_cnt", 64'(bus.retired_cnt), 64'd0);
    checkOutput("reset illegal_cnt", 64'(bus.illegal_cnt), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    $display("[TB] back-to-back stream of all ten operations");
    for (int k = 1; k < 32; k++) rf[k] = $urandom;
    evQ.delete();
    expQ.delete();
    monOn = 1'b1;
    for (int k = 0; k < 10; k++) txQ.push_back(mkR(k, k + 1, $urandom_range(0, 31), $urandom_range(0, 31)));
    runStream(1'b1, 100);
    repeat (6) @(negedge clk);
    checkEvents("b2b");
    checkOutput("b2b retired_cnt", 64'(bus.retired_cnt), 64'(expRet));

    $display("[TB] randomized stream");
    for (int k = 1; k < 32; k++) rf[k] = $urandom;
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7) begin
        w = mkR($urandom_range(0, 9), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      end else if (sel < 9) begin
        w = $urandom;
        w[6:0] = 7'b0110011;
      end else begin
        w = $urandom;
      end
      txQ.push_back(w);
    end
    runStream(1'b0, 2000);
    repeat (6) @(negedge clk);
    checkEvents("random");
    checkOutput("random retired_cnt", 64'(bus.retired_cnt), 64'(expRet));
    checkOutput("random illegal_cnt", 64'(bus.illegal_cnt), 64'(expIll));

    $display("[TB] reset during EXEC");
    rf[1] = 32'hF0F0_1234;
    rf[2] = 32'h0FF0_FF00;
    checkOutput("rst ready before", 64'(bus.instr_ready), 64'd1);
    bus.instr_valid = 1'b1;
    bus.instr = mkR(OP_AND, 7, 1, 2);
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst and enable", 64'(enVec), 64'(10'b0000010000));
    #2 rst = 1'b1;
    #1;
    checkOutput("rst enables", 64'(enVec), 64'd0);
    checkOutput("rst wr_en", 64'(bus.wr_en), 64'd0);
    checkOutput("rst done", 64'(bus.done), 64'd0);
    checkOutput("rst ready", 64'(bus.instr_ready), 64'd1);
    checkOutput("rst rs1_addr", 64'(bus.rs1_addr), 64'd0);
    checkOutput("rst rs2_addr", 64'(bus.rs2_addr), 64'd0);
    checkOutput("rst wr_addr", 64'(bus.wr_addr), 64'd0);
    checkOutput("rst wr_data", 64'(bus.wr_data), 64'd0);
    checkOutput("rst retired_cnt", 64'(bus.retired_cnt), 64'd0);
    checkOutput("rst illegal_cnt", 64'(bus.illegal_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    expRet = '0;
    expIll = '0;
    repeat (4) @(negedge clk);
    expQ.push_back(mkEv(2'd1, 10'b0000010000, 1'b0, 5'd0, 32'd0));
    checkEvents("rst");
    monOn = 1'b0;
    applyStimulus(vecs[0]);

    $display("[TB] counter wrap with CNT_W=2");
    bus2.instr_valid = 1'b1;
    bus2.instr = 32'h002081B3;
    nAcc = 0;
    for (int c = 0; c < 40 && nAcc < 5; c++) begin
      acc2 = bus2.instr_ready;
      @(posedge clk);
      if (acc2) nAcc++;
      @(negedge clk);
    end
    bus2.instr_valid = 1'b0;
    checkOutput("wrap accepted", 64'(nAcc), 64'd5);
    repeat (5) @(negedge clk);
    checkOutput("wrap retired_cnt", 64'(bus2.retired_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
